// File: rtl/ofdm_frame_deframer.sv
// ============================================================================
// Module   : ofdm_frame_deframer
// Purpose  : Receive-side OFDM deframer. Tags preamble samples, marks symbol
//            starts and end of frame, and flags mid-frame sop. Defining the
//            macro OFDM_DEFRAMER_CP_STRIP_EN drops cyclic-prefix samples.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ofdm_frame_deframer #(
  parameter int PREAMB_LEN    = 320,
  parameter int SYM_LEN       = 80,
  parameter int CP_LEN        = 16,
  parameter int SYM_PER_FRAME = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        valid_in,
  input  logic        sop_in,
  input  logic [15:0] I_in,
  input  logic [15:0] Q_in,
  output logic [15:0] I_out,
  output logic [15:0] Q_out,
  output logic        valid_out,
  output logic        preamb_flag,
  output logic        sos_out,
  output logic        eof_out,
  output logic        frame_err
);

`ifdef OFDM_DEFRAMER_CP_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif

  localparam int CNT_MAX = (PREAMB_LEN > SYM_LEN) ? PREAMB_LEN - 1 : SYM_LEN - 1;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int SYM_W   = (SYM_PER_FRAME < 2) ? 1 : $clog2(SYM_PER_FRAME);
  localparam int SOS_POS = STRIP ? CP_LEN : 0;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMB_LEN - 1);
  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SYM_LEN - 1);
  localparam logic [CNT_W-1:0] SOS_CNT   = CNT_W'(SOS_POS);
  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYM_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, PREAMB, PAYLOAD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [15:0]        i_q, i_d, q_q, q_d;
  logic               valid_q, valid_d, preamb_q, preamb_d;
  logic               sos_q, sos_d, eof_q, eof_d, err_q, err_d;

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    i_d        = i_q;
    q_d        = q_q;
    preamb_d   = preamb_q;
    valid_d    = 1'b0;
    sos_d      = 1'b0;
    eof_d      = 1'b0;
    err_d      = 1'b0;

    if (enable && valid_in) begin
      if (sop_in) begin
        // A sop always restarts the preamble, even when a frame is in flight.
        state_d    = PREAMB;
        samp_cnt_d = CNT_W'(1);
        sym_cnt_d  = '0;
        valid_d    = 1'b1;
        preamb_d   = 1'b1;
        i_d        = I_in;
        q_d        = Q_in;
        err_d      = (state_q != IDLE);
      end else begin
        case (state_q)
          PREAMB: begin
            valid_d  = 1'b1;
            preamb_d = 1'b1;
            i_d      = I_in;
            q_d      = Q_in;
            if (samp_cnt_q == PRE_LAST) begin
              state_d    = PAYLOAD;
              samp_cnt_d = '0;
              sym_cnt_d  = '0;
            end else begin
              samp_cnt_d = samp_cnt_q + 1'b1;
            end
          end
          PAYLOAD: begin
            // With CP stripping, SOS_CNT is the first kept sample; otherwise 0.
            if ((samp_cnt_q > SOS_CNT) || (samp_cnt_q == SOS_CNT)) begin
              valid_d  = 1'b1;
              preamb_d = 1'b0;
              i_d      = I_in;
              q_d      = Q_in;
              sos_d    = (samp_cnt_q == SOS_CNT);
            end
            if (samp_cnt_q == SAMP_LAST) begin
              samp_cnt_d = '0;
              if (sym_cnt_q == SYM_LAST) begin
                eof_d     = 1'b1;
                state_d   = IDLE;
                sym_cnt_d = '0;
              end else begin
                sym_cnt_d = sym_cnt_q + 1'b1;
              end
            end else begin
              samp_cnt_d = samp_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      sym_cnt_q  <= '0;
      i_q        <= '0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      preamb_q   <= 1'b0;
      sos_q      <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      i_q        <= i_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
      preamb_q   <= preamb_d;
      sos_q      <= sos_d;
      eof_q      <= eof_d;
      err_q      <= err_d;
    end
  end

  assign I_out       = i_q;
  assign Q_out       = q_q;
  assign valid_out   = valid_q;
  assign preamb_flag = preamb_q;
  assign sos_out     = sos_q;
  assign eof_out     = eof_q;
  assign frame_err   = err_q;

endmodule

`default_nettype wire

// File: doc/ofdm_frame_deframer.md
Name: ofdm_frame_deframer

Overview:
- Receive-side counterpart of the OFDM frame builder.
- Accepts a 16-bit signed I/Q sample stream carrying one frame per sop: preamble samples, then SYM_PER_FRAME OFDM symbols.
- Tags preamble samples for the synchronizer.
- Delimits symbols with start-of-symbol and end-of-frame markers.
- Flags framing errors before samples reach the FFT/demapper.

Parameters:
- PREAMB_LEN, 320, preamble length in samples (>=2)
- SYM_LEN, 80, samples per OFDM symbol including cyclic prefix (>=2)
- CP_LEN, 16, cyclic prefix length in samples (< SYM_LEN)
- SYM_PER_FRAME, 10, OFDM symbols per frame (>=1)

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- enable  input  1  global clock enable; low = full freeze
- valid_in  input  1  I_in/Q_in carry a sample this cycle
- sop_in  input  1  first sample of frame; qualified by valid_in
- I_in  input  16  signed in-phase sample
- Q_in  input  16  signed quadrature sample
- I_out  output  16  registered signed in-phase sample
- Q_out  output  16  registered signed quadrature sample
- valid_out  output  1  I_out/Q_out valid
- preamb_flag  output  1  output sample belongs to preamble
- sos_out  output  1  first forwarded sample of an OFDM symbol
- eof_out  output  1  last payload sample of frame
- frame_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Reset (async, active-high) clears all outputs: I_out/Q_out=0, valid_out=0, preamb_flag=0, sos_out=0, eof_out=0, frame_err=0. State returns to IDLE; samp_cnt=0, sym_cnt=0.
- All outputs are registered. Latency is 1 cycle from an accepted input to output.
- A sample is accepted when enable=1 and valid_in=1.
- enable=0: state, counters and outputs hold. valid_out, sos_out, eof_out and frame_err are forced 0 while enable=0.
- Any cycle without an accepted sample: valid_out=0, sos_out=0, eof_out=0, frame_err=0. I_out/Q_out hold their last value.
- FSM:
  - IDLE: an accepted sample with sop_in=1 is forwarded with preamb_flag=1. State goes to PREAMB with samp_cnt=1. An accepted sample with sop_in=0 is dropped (valid_out=0).
  - PREAMB: each accepted sample is forwarded with preamb_flag=1 and samp_cnt increments. The sample at samp_cnt==PREAMB_LEN-1 moves to PAYLOAD with samp_cnt=0, sym_cnt=0.
  - PAYLOAD: samples are forwarded with preamb_flag=0.
    - samp_cnt counts 0..SYM_LEN-1 and wraps to 0, incrementing sym_cnt.
    - sos_out=1 on the first forwarded sample of each symbol.
    - At samp_cnt==SYM_LEN-1 and sym_cnt==SYM_PER_FRAME-1, eof_out=1 and state returns to IDLE.
- Mid-frame sop (accepted sop_in=1 in PREAMB or PAYLOAD):
  - frame_err=1 for that output cycle.
  - The frame in progress is abandoned with no eof_out.
  - The sample is forwarded as preamble sample 0 (preamb_flag=1) and the FSM restarts in PREAMB with samp_cnt=1.
- sop_in with valid_in=0 is ignored in all states.
- Counters are sized with $clog2 of their respective maxima and never exceed them.
- Output data is pass-through with no arithmetic or saturation.
- Reset mid-frame discards the frame with no eof_out. The next frame requires a fresh sop.

Optional Feature:
- Macro: OFDM_DEFRAMER_CP_STRIP_EN.
- Defined:
  - In PAYLOAD, samples with samp_cnt < CP_LEN are consumed (counters advance) but not forwarded (valid_out=0).
  - sos_out marks the sample at samp_cnt==CP_LEN.
  - Forwarded samples per symbol = SYM_LEN-CP_LEN.
  - eof_out timing is unchanged.
- Undefined: all SYM_LEN samples are forwarded and sos_out marks samp_cnt==0. CP_LEN is unused.

Test Plan:
- Params PREAMB_LEN=4, SYM_LEN=6, CP_LEN=2, SYM_PER_FRAME=2, macro undefined. Continuous valid, sop on sample 0, I=sample index 0..15, Q=-I. Expect:
  - outputs 1 cycle later
  - preamb_flag=1 for I=0..3
  - sos_out at I=4,10
  - eof_out at I=15
  - return to IDLE; samples 16..19 without sop are dropped (valid_out=0).
- Same stream with OFDM_DEFRAMER_CP_STRIP_EN defined. Expect:
  - I=4,5,10,11 not forwarded
  - sos_out at I=6,12
  - eof_out at I=15
  - 8 payload outputs total
- valid_in toggled 1/0 every cycle and enable=0 for 3 cycles mid-PAYLOAD. Expect the identical output sequence (order and markers) to the first test, with gaps and no spurious valid_out.
- sop_in reasserted at I=7 (PAYLOAD, sym 0). Expect:
  - frame_err=1 on that sample's output, with preamb_flag=1
  - no eof_out for the aborted frame
  - next sos_out 4 accepted samples later
- reset asserted asynchronously at I=9. Expect all outputs 0 immediately. After release, samples without sop are dropped; a new sop frame behaves as in the first test.
- I_in=16'h8000, Q_in=16'h7FFF in preamble. Expect bit-exact pass-through: I_out=-32768, Q_out=32767.
